// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Holds the FSM encoding, word width and the default store depth.
package imem_fetch_responder_pkg;

    localparam int WORD_W     = 32;
    localparam int IMEM_DEPTH = 16;
    localparam int LAT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_e;

    // Full 32-bit compare so high PC bits never alias onto low store words.
    function automatic logic addr_out_of_range(input logic [WORD_W-1:0] addr,
                                               input int unsigned       depth);
        return addr >= depth;
    endfunction

endpackage

// File: rtl/imem_fetch_responder_store.sv
// Single-read/single-write synchronous instruction word array.
// Reads return the word held before any same-edge write.
module imem_fetch_responder_store
    import imem_fetch_responder_pkg::*;
#(
    parameter  int DEPTH = IMEM_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Program contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: accepts core fetch requests, serves words from
// a local store after a fixed latency, and counts acknowledged fetches.
//
//   state | meaning
//   IDLE  | waiting for fetch_req; accepts and reads the store
//   WAIT  | latency countdown, request inputs ignored
//   RESP  | one-cycle ack with data/err, count increments
module imem_fetch_responder
    import imem_fetch_responder_pkg::*;
#(
    parameter  int DEPTH   = IMEM_DEPTH,
    parameter  int LATENCY = 2,
    parameter  int CNT_W   = 16,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fetch_req_i,
    input  logic [WORD_W-1:0] fetch_addr_i,
    output logic              fetch_ack_o,
    output logic [WORD_W-1:0] fetch_data_o,
    output logic              fetch_err_o,
    output logic              busy_o,
    input  logic              load_we_i,
    input  logic [AW-1:0]     load_addr_i,
    input  logic [WORD_W-1:0] load_data_i,
    output logic [CNT_W-1:0]  fetch_count_o
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam fetch_state_e     FIRST_ST = (LATENCY > 1) ? ST_WAIT : ST_RESP;

    fetch_state_e      state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              oor_q, oor_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              in_resp;
    logic [WORD_W-1:0] store_rdata;
    logic [WORD_W-1:0] resp_word;

    imem_fetch_responder_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk_i   (clk_i),
        .we_i    (load_we_i),
        .waddr_i (load_addr_i),
        .wdata_i (load_data_i),
        .re_i    (accept),
        .raddr_i (fetch_addr_i[AW-1:0]),
        .rdata_o (store_rdata)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fetch_req_i) begin
                    accept  = 1'b1;
                    lat_d   = LAT_LOAD;
                    state_d = FIRST_ST;
                end
            end
            ST_WAIT: begin
                lat_d = lat_q - 1'b1;
                if (lat_q <= LAT_ONE) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_resp   = (state_q == ST_RESP);
    assign resp_word = oor_q ? '0 : store_rdata;

    always_comb begin
        oor_d  = oor_q;
        hold_d = hold_q;
        cnt_d  = cnt_q;
        if (accept) begin
            oor_d = addr_out_of_range(fetch_addr_i, DEPTH);
        end
        // The store read register is not reset, so the idle output comes from
        // a separately reset copy of the last delivered word.
        if (in_resp) begin
            hold_d = resp_word;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            oor_q   <= 1'b0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            oor_q   <= oor_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fetch_ack_o   = in_resp;
    assign fetch_err_o   = in_resp & oor_q;
    assign fetch_data_o  = in_resp ? resp_word : hold_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign fetch_count_o = cnt_q;

endmodule
